// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the N-way cache controller: FSM encodings, width
// helper and tree pseudo-LRU functions (trees up to 8 ways / 7 node bits).
package cache_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_LOOKUP     = 2'd0;
  localparam state_t ST_WRITE_BACK = 2'd1;
  localparam state_t ST_FILL       = 2'd2;

  localparam int PLRU_MAX_BITS = 7;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Walk the heap-ordered tree from the root; each node bit selects the half holding the victim.
  function automatic logic [2:0] plru_victim(input logic [PLRU_MAX_BITS-1:0] bits, input int ways);
    logic [2:0] node;
    logic [2:0] way;
    logic       dir;
    int         lg;
    node = 3'd0;
    way  = 3'd0;
    lg   = $clog2(ways);
    for (int lvl = 0; lvl < 3; lvl++) begin
      if (lvl < lg) begin
        dir  = bits[node];
        way  = {way[1:0], dir};
        node = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
      end
    end
    return way;
  endfunction

  function automatic logic [PLRU_MAX_BITS-1:0] plru_update(input logic [PLRU_MAX_BITS-1:0] bits,
                                                           input logic [2:0] way, input int ways);
    logic [PLRU_MAX_BITS-1:0] nb;
    logic [2:0]               node;
    logic [2:0]               ws;
    logic                     dir;
    int                       lg;
    nb   = bits;
    node = 3'd0;
    lg   = $clog2(ways);
    ws   = way << (3 - lg);
    for (int lvl = 0; lvl < 3; lvl++) begin
      if (lvl < lg) begin
        dir      = ws[2];
        nb[node] = ~dir;
        node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
        ws       = {ws[1:0], 1'b0};
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_plru_array.sv
// Per-set tree pseudo-LRU storage: combinational victim read, one update per cycle.
import cache_ctrl_pkg::*;

module plru_array #(
  parameter int WAYS = 4,
  parameter int SETS = 8,
  localparam int SW = width_of(SETS),
  localparam int WW = width_of(WAYS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] rd_set,
  output logic [WW-1:0] victim,
  input  logic          upd_en,
  input  logic [SW-1:0] upd_set,
  input  logic [WW-1:0] upd_way
);

  localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;

  logic [PW-1:0] tree_r [SETS];

  // Tree bit storage; with WAYS=1 the single dummy bit is never changed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        tree_r[s] <= {PW{1'b0}};
      end
    end else if (upd_en) begin
      tree_r[upd_set] <= PW'(plru_update(7'(tree_r[upd_set]), 3'(upd_way), WAYS));
    end
  end

  assign victim = WW'(plru_victim(7'(tree_r[rd_set]), WAYS));

endmodule

// File: rtl/cache_ctrl_nway.sv
// Control FSM for an N-way set-associative cache with multi-beat write-back
// and fill bursts; hits respond in the lookup cycle.
import cache_ctrl_pkg::*;

module cache_ctrl_nway #(
  parameter int WAYS       = 4,
  parameter int SETS       = 8,
  parameter int LINE_BEATS = 4,
  parameter int WRITE_BACK = 1,
  localparam int SW = width_of(SETS),
  localparam int BW = width_of(LINE_BEATS),
  localparam int WW = width_of(WAYS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [SW-1:0]   mem_set,
  input  logic [WAYS-1:0] hit_vec,
  input  logic [WAYS-1:0] valid_vec,
  input  logic [WAYS-1:0] dirty_vec,
  input  logic            pmem_resp,
  output logic            mem_resp,
  output logic            pmem_read,
  output logic            pmem_write,
  output logic            pmarmux_sel,
  output logic [BW-1:0]   beat_idx,
  output logic [WW-1:0]   victim_way,
  output logic            data_we,
  output logic            set_valid,
  output logic            set_dirty,
  output logic            clr_dirty
);

  localparam bit WB_EN = (WRITE_BACK != 0);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

  state_t        state_r, state_n;
  logic [BW-1:0] beat_r, beat_n;
  logic [WW-1:0] victim_r, victim_n;
  logic [SW-1:0] set_r, set_n;

  logic          req_s, hit_s, last_beat_s, victim_dirty_s;
  logic [WW-1:0] hit_way_s, miss_victim_s, plru_victim_s;
  logic          plru_upd_en_s;
  logic [SW-1:0] plru_upd_set_s;
  logic [WW-1:0] plru_upd_way_s;
  logic          mem_resp_s, pmem_read_s, pmem_write_s, pmarmux_s;
  logic          data_we_s, set_valid_s, set_dirty_s, clr_dirty_s;

  plru_array #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_set  (mem_set),
    .victim  (plru_victim_s),
    .upd_en  (plru_upd_en_s),
    .upd_set (plru_upd_set_s),
    .upd_way (plru_upd_way_s)
  );

  assign req_s       = mem_read | mem_write;
  assign hit_s       = |hit_vec;
  assign last_beat_s = (beat_r == LAST_BEAT);

  // Hit way encoding and victim choice: an empty way always beats the PLRU pick.
  always_comb begin
    hit_way_s     = {WW{1'b0}};
    miss_victim_s = plru_victim_s;
    for (int i = WAYS - 1; i >= 0; i--) begin
      hit_way_s     = hit_vec[i] ? WW'(i) : hit_way_s;
      miss_victim_s = valid_vec[i] ? miss_victim_s : WW'(i);
    end
  end

  assign victim_dirty_s = WB_EN & dirty_vec[miss_victim_s];

  // Next-state, burst sequencing and command decode.
  always_comb begin
    state_n        = state_r;
    beat_n         = beat_r;
    victim_n       = victim_r;
    set_n          = set_r;
    plru_upd_en_s  = 1'b0;
    plru_upd_set_s = mem_set;
    plru_upd_way_s = hit_way_s;
    mem_resp_s     = 1'b0;
    pmem_read_s    = 1'b0;
    pmem_write_s   = 1'b0;
    pmarmux_s      = 1'b0;
    data_we_s      = 1'b0;
    set_valid_s    = 1'b0;
    set_dirty_s    = 1'b0;
    clr_dirty_s    = 1'b0;
    case (state_r)
      ST_LOOKUP: begin
        if (req_s && hit_s) begin
          mem_resp_s    = 1'b1;
          set_dirty_s   = WB_EN & mem_write;
          plru_upd_en_s = 1'b1;
        end else if (req_s) begin
          victim_n = miss_victim_s;
          set_n    = mem_set;
          beat_n   = {BW{1'b0}};
          if (victim_dirty_s) begin
            state_n   = ST_WRITE_BACK;
            pmarmux_s = 1'b1;
          end else begin
            state_n = ST_FILL;
          end
        end else begin
          state_n = ST_LOOKUP;
        end
      end
      ST_WRITE_BACK: begin
        pmem_write_s = 1'b1;
        pmarmux_s    = 1'b1;
        if (pmem_resp && last_beat_s) begin
          beat_n  = {BW{1'b0}};
          state_n = ST_FILL;
        end else if (pmem_resp) begin
          beat_n = beat_r + BW'(1);
        end else begin
          beat_n = beat_r;
        end
      end
      ST_FILL: begin
        pmem_read_s = 1'b1;
        data_we_s   = pmem_resp;
        if (pmem_resp && last_beat_s) begin
          set_valid_s    = 1'b1;
          clr_dirty_s    = 1'b1;
          plru_upd_en_s  = 1'b1;
          plru_upd_set_s = set_r;
          plru_upd_way_s = victim_r;
          beat_n         = {BW{1'b0}};
          state_n        = ST_LOOKUP;
        end else if (pmem_resp) begin
          beat_n = beat_r + BW'(1);
        end else begin
          beat_n = beat_r;
        end
      end
      default: begin
        state_n = ST_LOOKUP;
        beat_n  = {BW{1'b0}};
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_LOOKUP;
      beat_r   <= {BW{1'b0}};
      victim_r <= {WW{1'b0}};
      set_r    <= {SW{1'b0}};
    end else begin
      state_r  <= state_n;
      beat_r   <= beat_n;
      victim_r <= victim_n;
      set_r    <= set_n;
    end
  end

  // Gating with rst_n drops any pmem request the instant reset asserts.
  assign mem_resp    = rst_n & mem_resp_s;
  assign pmem_read   = rst_n & pmem_read_s;
  assign pmem_write  = rst_n & pmem_write_s;
  assign pmarmux_sel = rst_n & pmarmux_s;
  assign data_we     = rst_n & data_we_s;
  assign set_valid   = rst_n & set_valid_s;
  assign set_dirty   = rst_n & set_dirty_s;
  assign clr_dirty   = rst_n & clr_dirty_s;
  assign beat_idx    = beat_r;
  assign victim_way  = victim_r;

endmodule
